// File: rtl/decode_cycle_pkg.sv
// Shared RV32I decode definitions for the ID stage: opcodes, control encodings,
// the ID/EX pipeline record and the immediate extender.
package decode_cycle_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_e;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm;
    logic              reg_write;
    logic              alu_src;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [1:0]        result_src;
    logic [2:0]        alu_ctrl;
  } idex_t;

  function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr, input imm_src_e src);
    logic [XLEN-1:0] imm;
    case (src)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_cycle_reg_file.sv
// 32x32 register file, two combinational reads and one write, x0 hardwired to
// zero; a same-cycle write is forwarded to the read ports.
module decode_cycle_reg_file
  import decode_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '{default: '0};
    else      regs_q <= regs_d;
  end

  // Bypass lets the ID/EX register capture the value being written this edge.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (wr_en && wa == ra1)  rd1 = wd;
    else if (ra1 != '0)      rd1 = regs_q[ra1];
    if (wr_en && wa == ra2)  rd2 = wd;
    else if (ra2 != '0)      rd2 = regs_q[ra2];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I ID stage: control/immediate decode, operand read, and the ID/EX
// pipeline register with bubble insertion on FlushE.
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic [REG_AW-1:0] Rs1D,
  output logic [REG_AW-1:0] Rs2D,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [REG_AW-1:0] RD_E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [XLEN-1:0]   Imm_Ext_E,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            reg_write, alu_src, mem_write, branch, jump, imm_en;
  imm_src_e        imm_src;
  result_src_e     result_src;
  alu_op_e         alu_op;
  alu_ctrl_e       alu_ctrl;
  logic [XLEN-1:0] imm_ext, rd1, rd2;
  idex_t           idex_d, idex_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  always_comb begin
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = RES_ALU;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    jump       = 1'b0;
    imm_en     = 1'b0;
    case (opcode)
      OP_LOAD:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = RES_MEM; imm_en = 1'b1; end
      OP_STORE:  begin imm_src = IMM_S; alu_src = 1'b1; mem_write = 1'b1; imm_en = 1'b1; end
      OP_RTYPE:  begin reg_write = 1'b1; alu_op = ALUOP_FUNCT; end
      OP_ITYPE:  begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALUOP_FUNCT; imm_en = 1'b1; end
      OP_BRANCH: begin imm_src = IMM_B; branch = 1'b1; alu_op = ALUOP_SUB; imm_en = 1'b1; end
      OP_JAL:    begin reg_write = 1'b1; imm_src = IMM_J; result_src = RES_PC4; jump = 1'b1; imm_en = 1'b1; end
      default:   ;
    endcase
  end

  // funct7[5] selects sub only for register-register ops; addi never subtracts.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (opcode == OP_RTYPE && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default:     alu_ctrl = ALU_ADD;
    endcase
  end

  assign imm_ext = imm_en ? imm_extend(InstrD, imm_src) : '0;

  decode_cycle_reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (RegWriteW),
    .wa  (RDW),
    .wd  (ResultW)
  );

  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.rd1        = rd1;
      idex_d.rd2        = rd2;
      idex_d.rd         = InstrD[11:7];
      idex_d.rs1        = Rs1D;
      idex_d.rs2        = Rs2D;
      idex_d.pc         = PCD;
      idex_d.pc_plus4   = PCPlus4D;
      idex_d.imm        = imm_ext;
      idex_d.reg_write  = reg_write;
      idex_d.alu_src    = alu_src;
      idex_d.mem_write  = mem_write;
      idex_d.branch     = branch;
      idex_d.jump       = jump;
      idex_d.result_src = result_src;
      idex_d.alu_ctrl   = alu_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign RD1_E       = idex_q.rd1;
  assign RD2_E       = idex_q.rd2;
  assign RD_E        = idex_q.rd;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign Imm_Ext_E   = idex_q.imm;
  assign RegWriteE   = idex_q.reg_write;
  assign ALUSrcE     = idex_q.alu_src;
  assign MemWriteE   = idex_q.mem_write;
  assign BranchE     = idex_q.branch;
  assign JumpE       = idex_q.jump;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_ctrl;

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- ID stage of the 5-stage RV32I pipeline. Sits between the fetch register (IF/ID) and execute_cycle.
- Decodes InstrD into control signals. Reads two operands from the internal register file, which the writeback port updates, and sign-extends the immediate.
- Registers everything into the ID/EX pipeline register that drives execute_cycle.
- Supports FlushE bubble insertion for the hazard unit.

Parameters:
- XLEN, 32, datapath width
- NREG, 32, architectural register count (index width 5)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback enable
- RDW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  load bubble into ID/EX this edge
- Rs1D  out  5  InstrD[19:15], combinational, for hazard unit
- Rs2D  out  5  InstrD[24:20], combinational
- RD1_E, RD2_E  out  32  registered operands
- RD_E  out  5  registered destination (InstrD[11:7])
- Rs1E, Rs2E  out  5  registered source indices, for forwarding
- PCE, PCPlus4E, Imm_Ext_E  out  32  registered
- RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE  out  1  registered controls
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt

Behaviour:
- Reset (rst=0, async): every ID/EX output is 0; all 32 register-file entries are 0.
- Opcode decode (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump):
  - lw 0000011 -> 1, I, 1, 0, 01, 0, 00, 0
  - sw 0100011 -> 0, S, 1, 1, xx->00, 0, 00, 0
  - R 0110011 -> 1, -, 0, 0, 00, 0, 10, 0
  - I-ALU 0010011 -> 1, I, 1, 0, 00, 0, 10, 0
  - beq 1100011 -> 0, B, 0, 0, 00, 1, 01, 0
  - jal 1101111 -> 1, J, -, 0, 10, 0, -, 1
  - Any other opcode: all controls 0, ImmExt 0 (behaves as NOP).
- ALU decode:
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10 by funct3:
    - 000 -> sub only if opcode is R-type and funct7[5]=1, else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other -> add
- Immediate (all sign-extended from InstrD[31]):
  - I = Instr[31:20]
  - S = {Instr[31:25], Instr[11:7]}
  - B = {Instr[7], Instr[30:25], Instr[11:8], 0}
  - J = {Instr[19:12], Instr[20], Instr[30:21], 0}
- Register file:
  - Two combinational read ports, one write port on posedge clk when RegWriteW=1 and RDW!=0.
  - x0 always reads 0, and writes to it are dropped.
  - Same-cycle bypass: if RegWriteW=1, RDW!=0 and RDW equals the read index, the read returns ResultW.
- ID/EX register, updated on posedge clk:
  - FlushE=1: all fields load 0, giving a bubble with no RegWrite, MemWrite, Branch or Jump.
  - FlushE=0: all fields load the decoded values.
  - The writeback write and the ID/EX capture occur on the same edge; the bypass guarantees RD1_E/RD2_E capture ResultW.
- Latency: one cycle from InstrD to the *E outputs.
- Reset mid-operation clears the ID/EX register and register-file contents immediately. First valid output appears on the first edge after rst deasserts.

Decomposition:
- Shared header (riscv_defs.vh) holds:
  - opcode constants
  - ALUControl encodings (add/sub/and/or/slt)
  - ImmSrc encodings (I=00, S=01, B=10, J=11)
  - ResultSrc encodings
  - ALUOp encodings
- Sub-module reg_file (32x32, 2R1W, x0 hardwired, write-through bypass), instantiated once.
- Control and immediate decode stay inline as combinational logic.

Test Plan:
- Reset, then release; write x5=0x1234 via W port; next cycle decode add x6,x5,x0 (0x00028333) -> RD1_E=0x1234, RD_E=6, RegWriteE=1, ALUSrcE=0, ALUControlE=000.
- Bypass: RegWriteW=1, RDW=7, ResultW=0xDEADBEEF in the same cycle as decoding sub x8,x7,x7 (0x40738433) -> RD1_E=RD2_E=0xDEADBEEF, ALUControlE=001.
- Immediates:
  - lw x1,-4(x2) (0xFFC12083) -> Imm_Ext_E=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1.
  - sw x1,8(x2) (0x00112423) -> Imm_Ext_E=8, MemWriteE=1, RegWriteE=0.
- Control flow:
  - beq x0,x0,-8 (0xFE000CE3) -> BranchE=1, Imm_Ext_E=0xFFFFFFF8, ALUControlE=001.
  - jal x1,16 (0x010000EF) -> JumpE=1, ResultSrcE=10, Imm_Ext_E=16.
- x0 and illegal opcode:
  - Write RDW=0, ResultW=5, then decode add x9,x0,x0 -> RD1_E=0.
  - InstrD=0xFFFFFFFF -> all controls 0.
- FlushE=1 while decoding a valid sw -> all *E outputs 0. Assert rst low mid-stream -> outputs 0 asynchronously, and register contents read 0 afterwards.
